// File: rtl/systolic_scheduler_pkg.sv
// Shared state encoding and parameter defaults for the systolic array feed scheduler.
package sched_pkg;

    localparam int N_DEF     = 4;
    localparam int K_MAX_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        FEED  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Width of a counter that must reach k_max + 2n - 3 without wrapping.
    function automatic int t_width(input int n, input int k_max);
        int w;
        w = $clog2(k_max + 2 * n - 2);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/systolic_scheduler_if.sv
// Job request / array feed bundle between a job source and the systolic scheduler.
interface systolic_scheduler_if import sched_pkg::*; #(
    parameter int N  = N_DEF,
    parameter int KW = $clog2(K_MAX_DEF + 1)
) ();

    logic            go_i;
    logic [KW-1:0]   k_len_i;
    logic            busy_o;
    logic            done_o;
    logic            res_valid_o;
    logic            pe_start_o;
    logic [N*KW-1:0] lane_k_o;
    logic [N-1:0]    lane_valid_o;
    logic [N*N-1:0]  ovf_i;
    logic            ovf_o;

    modport master (
        output go_i, k_len_i, ovf_i,
        input  busy_o, done_o, res_valid_o, pe_start_o, lane_k_o, lane_valid_o, ovf_o
    );

    modport slave (
        input  go_i, k_len_i, ovf_i,
        output busy_o, done_o, res_valid_o, pe_start_o, lane_k_o, lane_valid_o, ovf_o
    );

endinterface

// File: rtl/systolic_scheduler_lane_skew.sv
// Purpose: operand index and valid for one feed lane, delayed by its lane number.
// Latency: combinational.
// Backpressure: none; follows the caller's cycle counter.
module lane_skew import sched_pkg::*; #(
    parameter int KW = 5,
    parameter int TW = 5
) (
    input  logic [TW-1:0] t,
    input  logic [KW-1:0] lane,
    input  logic [KW-1:0] k_len,
    output logic [KW-1:0] lane_k,
    output logic          lane_valid
);

    localparam int WW = ((TW > KW) ? TW : KW) + 1;

    logic [WW-1:0] t_w;
    logic [WW-1:0] lo_w;
    logic [WW-1:0] hi_w;

    // One extra bit so lane + k_len cannot wrap past the counter range.
    assign t_w  = WW'(t);
    assign lo_w = WW'(lane);
    assign hi_w = WW'(lane) + WW'(k_len);

    assign lane_valid = (t_w >= lo_w) && (t_w < hi_w);
    assign lane_k     = lane_valid ? KW'(t_w - lo_w) : '0;

endmodule

// File: rtl/systolic_scheduler.sv
// Purpose: sequences CLEAR/FEED/DONE for an NxN systolic array; SYSTOLIC_SCHED_OVF_EN adds a sticky overflow flag.
// Latency: go -> CLEAR next cycle, FEED for k_len+2N-2 cycles, done_o on entry to DONE.
// Backpressure: none; go_i is accepted only in IDLE or DONE and dropped otherwise.
module systolic_scheduler import sched_pkg::*; #(
    parameter int N     = N_DEF,
    parameter int K_MAX = K_MAX_DEF,
    parameter int KW    = $clog2(K_MAX + 1)
) (
    input logic                clk_i,
    input logic                rst_ni,
    systolic_scheduler_if.slave bus
);

    localparam int TW = t_width(N, K_MAX);

    state_t        state_q, state_d;
    logic [KW-1:0] k_len_q;
    logic [KW-1:0] k_sat;
    logic [TW-1:0] t_q;
    logic [TW-1:0] last_t;
    logic          done_q;
    logic          accept;
    logic          feed;
    logic          feed_last;
    logic          pe_start;

    logic [N-1:0]    lane_valid;
    logic [N*KW-1:0] lane_k;

    assign accept    = bus.go_i && ((state_q == IDLE) || (state_q == DONE));
    assign k_sat     = (bus.k_len_i > KW'(K_MAX)) ? KW'(K_MAX) : bus.k_len_i;
    assign feed      = (state_q == FEED);
    assign last_t    = TW'(k_len_q) + TW'(2 * N - 3);
    assign feed_last = feed && (t_q == last_t);
    assign pe_start  = (state_q == FEED) || (state_q == DONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.go_i) state_d = CLEAR;
            CLEAR:   state_d = (k_len_q == '0) ? DONE : FEED;
            FEED:    if (feed_last) state_d = DONE;
            DONE:    if (bus.go_i) state_d = CLEAR;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            k_len_q <= '0;
            t_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) k_len_q <= k_sat;
            // Counter idles at zero so every FEED phase starts from t = 0.
            t_q    <= (feed && !feed_last) ? t_q + 1'b1 : '0;
            done_q <= (state_d == DONE) && (state_q != DONE);
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [KW-1:0] k_i;
        logic          v_i;

        lane_skew #(.KW(KW), .TW(TW)) u_skew (
            .t          (t_q),
            .lane       (KW'(i)),
            .k_len      (k_len_q),
            .lane_k     (k_i),
            .lane_valid (v_i)
        );

        assign lane_valid[i]         = feed && v_i;
        assign lane_k[i*KW +: KW]    = (feed && v_i) ? k_i : '0;
    end

    assign bus.busy_o       = (state_q == CLEAR) || (state_q == FEED);
    assign bus.done_o       = done_q;
    assign bus.res_valid_o  = (state_q == DONE);
    assign bus.pe_start_o   = pe_start;
    assign bus.lane_valid_o = lane_valid;
    assign bus.lane_k_o     = lane_k;

`ifdef SYSTOLIC_SCHED_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_q <= 1'b0;
        end else if (state_q == CLEAR) begin
            ovf_q <= 1'b0;
        end else if (pe_start && (|bus.ovf_i)) begin
            ovf_q <= 1'b1;
        end
    end

    assign bus.ovf_o = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ^bus.ovf_i;
    assign bus.ovf_o  = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_scheduler.sv
// Scoreboard bench for systolic_scheduler: expected per-cycle outputs are queued at go time and popped each cycle.
module tb_systolic_scheduler;
    import sched_pkg::*;

    localparam int N     = 4;
    localparam int K_MAX = 16;
    localparam int KW    = 5;
`ifdef SYSTOLIC_SCHED_OVF_EN
    localparam logic EXP_OVF = 1'b1;
`else
    localparam logic EXP_OVF = 1'b0;
`endif

    typedef struct packed {
        logic            busy;
        logic            done;
        logic            res_valid;
        logic            pe_start;
        logic [N-1:0]    lane_valid;
        logic [N*KW-1:0] lane_k;
        logic            ovf;
    } obs_t;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    systolic_scheduler_if #(.N(N), .KW(KW)) bus ();

    systolic_scheduler #(.N(N), .K_MAX(K_MAX), .KW(KW)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus.slave)
    );

    obs_t exp_q[$];
    obs_t hist[$];
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic obs_t sample();
        obs_t a;
        a.busy       = bus.busy_o;
        a.done       = bus.done_o;
        a.res_valid  = bus.res_valid_o;
        a.pe_start   = bus.pe_start_o;
        a.lane_valid = bus.lane_valid_o;
        a.lane_k     = bus.lane_k_o;
        a.ovf        = bus.ovf_o;
        return a;
    endfunction

    function automatic logic [KW-1:0] lane_k_of(input obs_t o, input int i);
        logic [N*KW-1:0] v;
        v = o.lane_k;
        return v[i*KW +: KW];
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Expected trace of one job, starting at its CLEAR cycle.
    task automatic push_job(input int k_in, input int hold, output int done_idx);
        int   k;
        obs_t e;
        k = (k_in > K_MAX) ? K_MAX : k_in;
        e = '0;
        e.busy = 1'b1;
        exp_q.push_back(e);
        if (k > 0) begin
            for (int t = 0; t < k + 2 * N - 2; t++) begin
                logic [N*KW-1:0] lk;
                e = '0;
                lk = '0;
                e.busy = 1'b1;
                e.pe_start = 1'b1;
                for (int i = 0; i < N; i++) begin
                    if (t >= i && t < i + k) begin
                        e.lane_valid[i] = 1'b1;
                        lk[i*KW +: KW] = KW'(t - i);
                    end
                end
                e.lane_k = lk;
                exp_q.push_back(e);
            end
        end
        done_idx = exp_q.size();
        e = '0;
        e.done = 1'b1;
        e.res_valid = 1'b1;
        e.pe_start = 1'b1;
        exp_q.push_back(e);
        e.done = 1'b0;
        for (int h = 0; h < hold; h++) exp_q.push_back(e);
    endtask

    task automatic start_job(input int k);
        bus.k_len_i = KW'(k);
        bus.go_i    = 1'b1;
        tick();
        bus.go_i    = 1'b0;
    endtask

    task automatic run_sb(input string name, input int go_at, input int go_k, input int stop_at);
        int idx = 0;
        hist.delete();
        while (exp_q.size() > 0) begin
            obs_t e, a;
            e = exp_q.pop_front();
            a = sample();
            hist.push_back(a);
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL %s cycle %0d: got %h expected %h", name, idx, a, e);
            end
            if (idx == stop_at) break;
            if (idx == go_at) begin
                bus.go_i    = 1'b1;
                bus.k_len_i = KW'(go_k);
            end
            tick();
            bus.go_i = 1'b0;
            idx++;
        end
    endtask

    task automatic check_zero(input string name);
        obs_t a;
        a = sample();
        vectors++;
        if (a !== obs_t'(0)) begin
            miscompares++;
            $display("FAIL %s: got %h expected 0", name, a);
        end
    endtask

    task automatic test_reset();
        bus.go_i = 1'b0; bus.k_len_i = '0; bus.ovf_i = '0;
        rst_ni = 1'b0;
        #2;
        check_zero("reset_async");
        tick();
        bus.go_i = 1'b1; bus.k_len_i = 5'd3;
        tick();
        check_zero("reset_held_go");
        bus.go_i = 1'b0;
        rst_ni = 1'b1;
        tick();
        check_zero("reset_idle");
    endtask

    task automatic test_basic();
        int d;
        push_job(3, 2, d);
        start_job(3);
        run_sb("basic", -1, 0, -1);
        vectors++;
        if (hist[0].pe_start !== 1'b0 || hist[0].busy !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_clear: pe_start %b busy %b expected 0 1", hist[0].pe_start, hist[0].busy);
        end
        for (int j = 0; j < 3; j++) begin
            vectors++;
            if (hist[1+j].lane_valid[0] !== 1'b1 || lane_k_of(hist[1+j], 0) !== KW'(j)) begin
                miscompares++;
                $display("FAIL basic_lane0 c+%0d: valid %b k %0d expected 1 %0d",
                         2 + j, hist[1+j].lane_valid[0], lane_k_of(hist[1+j], 0), j);
            end
        end
        for (int j = 3; j < 8; j++) begin
            vectors++;
            if (hist[j].lane_valid[3] !== ((j >= 4) && (j <= 6))) begin
                miscompares++;
                $display("FAIL basic_lane3 c+%0d: valid %b", j + 1, hist[j].lane_valid[3]);
            end
        end
        vectors++;
        if (hist[10].done !== 1'b1 || hist[10].res_valid !== 1'b1 || hist[9].res_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_done c+11: done %b res_valid %b expected 1 1", hist[10].done, hist[10].res_valid);
        end
    endtask

    task automatic test_ignore_go();
        int d, n;
        push_job(3, 1, d);
        start_job(3);
        run_sb("ignore_go", 4, 7, -1);
        n = 0;
        foreach (hist[j]) if (hist[j].done) n++;
        vectors++;
        if (n !== 1 || hist[10].done !== 1'b1) begin
            miscompares++;
            $display("FAIL ignore_go: %0d done pulses, c+11 done %b, expected 1 1", n, hist[10].done);
        end
    endtask

    task automatic test_zero_k();
        int d;
        logic [N-1:0] any;
        push_job(0, 1, d);
        start_job(0);
        run_sb("zero_k", -1, 0, -1);
        any = '0;
        foreach (hist[j]) any = any | hist[j].lane_valid;
        vectors++;
        if (any !== '0 || hist[1].done !== 1'b1) begin
            miscompares++;
            $display("FAIL zero_k: lanes seen %b done at c+2 %b, expected 0 1", any, hist[1].done);
        end
    endtask

    task automatic test_clamp();
        int d, feed_n;
        logic [KW-1:0] last_k;
        push_job(20, 1, d);
        start_job(20);
        run_sb("clamp", -1, 0, -1);
        feed_n = 0;
        last_k = '1;
        foreach (hist[j]) begin
            if (hist[j].busy && hist[j].pe_start) feed_n++;
            if (hist[j].lane_valid[0]) last_k = lane_k_of(hist[j], 0);
        end
        vectors++;
        if (feed_n !== 22 || last_k !== 5'd15) begin
            miscompares++;
            $display("FAIL clamp: feed cycles %0d lane0 last k %0d, expected 22 15", feed_n, last_k);
        end
    endtask

    task automatic test_back_to_back();
        int d1, d2, n;
        push_job(3, 0, d1);
        push_job(2, 1, d2);
        start_job(3);
        run_sb("back_to_back", d1, 2, -1);
        n = 0;
        foreach (hist[j]) if (hist[j].done) n++;
        vectors++;
        if (n !== 2 || hist[d1+1].busy !== 1'b1 || hist[d1+1].pe_start !== 1'b0) begin
            miscompares++;
            $display("FAIL back_to_back: %0d done pulses, next busy %b pe_start %b, expected 2 1 0",
                     n, hist[d1+1].busy, hist[d1+1].pe_start);
        end
    endtask

    task automatic test_reset_mid();
        int d;
        push_job(3, 0, d);
        start_job(3);
        run_sb("reset_mid_pre", -1, 0, 5);
        rst_ni = 1'b0;
        #1;
        check_zero("reset_mid_async");
        exp_q.delete();
        tick();
        check_zero("reset_mid_held");
        rst_ni = 1'b1;
        for (int j = 0; j < 6; j++) begin
            tick();
            check_zero("reset_mid_after");
        end
        push_job(2, 1, d);
        start_job(2);
        run_sb("reset_mid_rerun", -1, 0, -1);
    endtask

    task automatic test_ovf();
        int guard;
        start_job(3);
        tick();
        bus.ovf_i = '0;
        bus.ovf_i[5] = 1'b1;
        tick();
        bus.ovf_i = '0;
        guard = 0;
        while (!bus.res_valid_o && guard < 40) begin
            vectors++;
            if (bus.ovf_o !== EXP_OVF) begin
                miscompares++;
                $display("FAIL ovf_feed: ovf_o %b expected %b", bus.ovf_o, EXP_OVF);
            end
            tick();
            guard++;
        end
        vectors++;
        if (!bus.res_valid_o || bus.ovf_o !== EXP_OVF) begin
            miscompares++;
            $display("FAIL ovf_done: res_valid %b ovf_o %b expected 1 %b", bus.res_valid_o, bus.ovf_o, EXP_OVF);
        end
        start_job(1);
        tick();
        vectors++;
        if (bus.ovf_o !== 1'b0 || bus.pe_start_o !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_cleared: ovf_o %b pe_start %b expected 0 1", bus.ovf_o, bus.pe_start_o);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignore_go();
        test_zero_k();
        test_clamp();
        test_back_to_back();
        test_reset_mid();
        test_ovf();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, vectors %0d", vectors);
        $fatal(1);
    end

endmodule

// File: doc/systolic_scheduler.md
SYSTOLIC_SCHEDULER -- requirements
Module: systolic_scheduler

Interface
REQ-001 Parameter N, default 4: systolic array dimension, N x N PEs, N feed lanes.
REQ-002 Parameter K_MAX, default 16: maximum inner dimension per job.
REQ-003 Parameter KW, default $clog2(K_MAX+1): width of the k-length and lane-index fields.
REQ-004 clk_i  in  1  clock; all state updates on the rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 go_i  in  1  job request; sampled only in IDLE or DONE.
REQ-007 k_len_i  in  KW  inner dimension of the job; sampled with go_i.
REQ-008 busy_o  out  1  high in CLEAR and FEED.
REQ-009 done_o  out  1  one-cycle completion pulse.
REQ-010 res_valid_o  out  1  array results are final and stable.
REQ-011 pe_start_o  out  1  start line broadcast to all PEs; low clears the accumulators.
REQ-012 lane_k_o  out  N*KW  per-lane operand index; lane i occupies bits [i*KW +: KW].
REQ-013 lane_valid_o  out  N  per-lane operand valid; an invalid lane feeds zero.
REQ-014 ovf_i  in  N*N  per-PE overflow flags.
REQ-015 ovf_o  out  1  sticky job overflow.

Function
REQ-016 States SHALL be IDLE, CLEAR, FEED and DONE.
REQ-017 IDLE with go_i high SHALL go to CLEAR; DONE with go_i high SHALL also go to CLEAR, so jobs run back-to-back.
REQ-018 go_i in CLEAR or FEED SHALL be ignored, with no queueing.
REQ-019 The latched k_len SHALL saturate to K_MAX when k_len_i exceeds K_MAX.
REQ-020 CLEAR SHALL last exactly 1 cycle with pe_start_o=0 and all lanes invalid.
REQ-021 CLEAR SHALL go to DONE when the latched k_len is 0, and to FEED otherwise.
REQ-022 FEED SHALL last exactly k_len+2N-2 cycles, using cycle counter t = 0 .. k_len+2N-3, with pe_start_o=1.
REQ-023 In FEED, lane i SHALL be valid when i <= t < i+k_len, with lane_k_o[i] = t-i; otherwise lane_k_o[i]=0 and the lane is invalid.
REQ-024 The same lane i skew SHALL apply to A row i and B column i.
REQ-025 The last FEED cycle SHALL go to DONE.
REQ-026 The t counter width SHALL hold K_MAX+2N-3 without wrap.
REQ-027 On entry to DONE, done_o SHALL pulse for exactly 1 cycle.
REQ-028 In DONE, res_valid_o=1 and pe_start_o stays 1; zero-fed lanes keep the accumulators unchanged.
REQ-029 DONE SHALL be held until the next go_i.
REQ-030 res_valid_o SHALL be 0 from the cycle after go_i is accepted until DONE.

Reset
REQ-031 Asynchronous assertion of reset SHALL force state IDLE, t=0 and latched k_len=0.
REQ-032 During and after reset, busy_o, done_o, res_valid_o, pe_start_o, lane_valid_o, lane_k_o and ovf_o SHALL all be 0.
REQ-033 Reset during FEED SHALL abort the job immediately with no done_o.
REQ-034 The first go_i after reset SHALL start a normal job.

Configuration
REQ-035 With SYSTOLIC_SCHED_OVF_EN defined, ovf_o SHALL be set when any ovf_i bit is high while pe_start_o=1 in FEED or DONE.
REQ-036 With the macro defined, ovf_o SHALL be sticky and cleared only in CLEAR or by reset.
REQ-037 Without the macro, ovf_o SHALL be tied 0, ovf_i SHALL be unused, and no overflow flop SHALL exist.

Structure
REQ-038 Package sched_pkg SHALL hold the state encoding constants (IDLE, CLEAR, FEED, DONE) and the defaults for N and K_MAX.
REQ-039 Sub-module lane_skew SHALL hold one lane's skew logic: inputs t, lane number and k_len; outputs lane_k and lane_valid.
REQ-040 The top level SHALL instantiate lane_skew N times in a generate loop.

Verification
REQ-041 N=4; go_i=1 at cycle c with k_len_i=3 -> pe_start_o=0 at c+1; FEED c+2..c+10; lane0 valid c+2..c+4 with k=0,1,2; lane3 valid c+5..c+7; done_o and res_valid_o at c+11.
REQ-042 go_i pulsed at c+5 of the REQ-041 job -> ignored; done_o still at c+11 only.
REQ-043 k_len_i=0 -> CLEAR at c+1; done_o at c+2; no lane ever valid.
REQ-044 k_len_i=20 -> clamped to 16; FEED = 22 cycles; lane0 last k=15.
REQ-045 rst_ni low at c+6 of the REQ-041 job -> all outputs 0 immediately; no done_o; next go_i runs normally.
REQ-046 With SYSTOLIC_SCHED_OVF_EN defined, ovf_i[5]=1 for 1 cycle in FEED -> ovf_o=1 through DONE, cleared at the next CLEAR; without the macro, ovf_o stays 0.
